// File: rtl/scandoubler_pkg.sv
// Shared types and defaults for the scandoubler line-doubling stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package scandoubler_pkg;

    // Default bits per colour channel.
    localparam int DEF_COLOR_DEPTH = 6;

    // One pixel: {R, G, B}, packed.
    typedef logic [3*DEF_COLOR_DEPTH-1:0] rgb_t;

    // Attenuation applied to the repeated line when scanlines are built in.
    typedef enum logic [1:0] {
        SL_OFF = 2'b00,
        SL_25  = 2'b01,
        SL_50  = 2'b10,
        SL_75  = 2'b11
    } sl_level_t;

endpackage

// File: rtl/sd_line_buffer.sv
// Two-line pixel store: one write port, one registered read port.
// Latency: 1 read-enable tick from rd_addr to rd_dat.
// Backpressure: none; writer and reader always address different lines.
//
// Ports: we/wr_addr/wr_dat write side, re/rd_addr/rd_dat read side.
module sd_line_buffer
    import scandoubler_pkg::*;
#(
    parameter int AW = 11,
    parameter int DW = $bits(rgb_t)
) (
    input  logic          clk_sys,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk_sys) begin
        if (we) mem[wr_addr] <= wr_dat;
    end

    always_ff @(posedge clk_sys) begin
        if (re) rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/scandoubler.sv
// Captures 15 kHz RGB into a two-line buffer and replays each line twice at 2x rate.
// Latency: one input line + 1 ce_x2 tick (2 ticks with SCANDOUBLER_SCANLINES_EN); bypass 1 clk_sys.
// Backpressure: none; fully driven by the ce_x1 / ce_x2 enables.
//
// Ports: clk_sys, reset (sync, active-high), ce_x1/ce_x2 pixel enables, bypass,
//        scanlines (only with SCANDOUBLER_SCANLINES_EN), R/G/B_in + HSync_in/VSync_in,
//        R/G/B_out + HSync/VSync (all syncs active-low).
module scandoubler
    import scandoubler_pkg::*;
#(
    parameter int HCNT_WIDTH  = 10,
    parameter int COLOR_DEPTH = DEF_COLOR_DEPTH
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   ce_x1,
    input  logic                   ce_x2,
    input  logic                   bypass,
`ifdef SCANDOUBLER_SCANLINES_EN
    input  logic [1:0]             scanlines,
`endif
    input  logic [COLOR_DEPTH-1:0] R_in,
    input  logic [COLOR_DEPTH-1:0] G_in,
    input  logic [COLOR_DEPTH-1:0] B_in,
    input  logic                   HSync_in,
    input  logic                   VSync_in,
    output logic [COLOR_DEPTH-1:0] R_out,
    output logic [COLOR_DEPTH-1:0] G_out,
    output logic [COLOR_DEPTH-1:0] B_out,
    output logic                   HSync,
    output logic                   VSync
);

    localparam int CW = 3 * COLOR_DEPTH;
    localparam logic [HCNT_WIDTH-1:0] HCNT_MAX = '1;

    logic [HCNT_WIDTH-1:0] hcnt_in, hcnt_out, line_len, hs_len;
    logic                  wr_line, rd_line, sd_line, hs_prev;
    logic [1:0]            lines_seen;
    logic                  line_start, hs_rise, hcnt_sat;
    logic                  wr_we;
    logic [HCNT_WIDTH:0]   wr_addr;
    logic [CW-1:0]         rd_dat;

    assign hcnt_sat   = (hcnt_in == HCNT_MAX);
    assign line_start = ce_x1 && hs_prev && !HSync_in;
    assign hs_rise    = ce_x1 && !hs_prev && HSync_in;

    // The pixel on the line-start tick is column 0 of the new line, so it goes
    // straight to address 0 of the other half and the counter resumes at 1.
    // hcnt_in therefore equals the number of pixels captured so far, which makes
    // line_len the true line length and hs_len the true sync width.
    assign wr_we   = ce_x1 && (line_start || !hcnt_sat);
    assign wr_addr = line_start ? {~wr_line, {HCNT_WIDTH{1'b0}}} : {wr_line, hcnt_in};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hcnt_in    <= '0;
            line_len   <= '0;
            hs_len     <= '0;
            wr_line    <= 1'b0;
            rd_line    <= 1'b0;
            hs_prev    <= 1'b1;
            lines_seen <= 2'd0;
        end else if (ce_x1) begin
            hs_prev <= HSync_in;
            if (line_start) begin
                line_len <= hcnt_in;
                hcnt_in  <= HCNT_WIDTH'(1);
                rd_line  <= wr_line;
                wr_line  <= ~wr_line;
                if (lines_seen != 2'd2) lines_seen <= lines_seen + 2'd1;
            end else if (!hcnt_sat) begin
                hcnt_in <= hcnt_in + HCNT_WIDTH'(1);
            end
            if (hs_rise) hs_len <= hcnt_in;
        end
    end

    // Output counter: wraps at line_len so each line plays twice per input line;
    // an input line start re-phases it to the first copy.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hcnt_out <= '0;
            sd_line  <= 1'b0;
        end else if (ce_x2) begin
            if (line_start) begin
                hcnt_out <= '0;
                sd_line  <= 1'b0;
            end else if (line_len != '0 && hcnt_out == line_len - HCNT_WIDTH'(1)) begin
                hcnt_out <= '0;
                sd_line  <= 1'b1;
            end else begin
                hcnt_out <= hcnt_out + HCNT_WIDTH'(1);
            end
        end
    end

    sd_line_buffer #(
        .AW (HCNT_WIDTH + 1),
        .DW (CW)
    ) u_buf (
        .clk_sys (clk_sys),
        .we      (wr_we),
        .wr_addr (wr_addr),
        .wr_dat  ({R_in, G_in, B_in}),
        .re      (ce_x2),
        .rd_addr ({rd_line, hcnt_out}),
        .rd_dat  (rd_dat)
    );

    // Stage 1 runs alongside the registered RAM read. ok_s1 blanks the picture
    // until a full line has been captured since reset (the first line after a
    // reset is only a partial one).
    logic hs_s1, vs_s1, ok_s1;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_s1 <= 1'b1;
            vs_s1 <= 1'b1;
            ok_s1 <= 1'b0;
        end else if (ce_x2) begin
            hs_s1 <= !(hcnt_out < hs_len);
            if (hcnt_out == '0) vs_s1 <= VSync_in;
            ok_s1 <= (lines_seen == 2'd2);
        end
    end

    logic [CW-1:0] vid_rgb;
    logic          vid_hs, vid_vs;

`ifdef SCANDOUBLER_SCANLINES_EN
    function automatic logic [COLOR_DEPTH-1:0] atten(input logic [COLOR_DEPTH-1:0] x,
                                                     input logic [1:0] lvl);
        case (sl_level_t'(lvl))
            SL_OFF:  return x;
            SL_25:   return x - (x >> 2);
            SL_50:   return x >> 1;
            default: return x >> 2;
        endcase
    endfunction

    logic          sd_s1, hs_s2, vs_s2;
    logic [CW-1:0] rgb_s2;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sd_s1  <= 1'b0;
            hs_s2  <= 1'b1;
            vs_s2  <= 1'b1;
            rgb_s2 <= '0;
        end else if (ce_x2) begin
            sd_s1 <= sd_line;
            hs_s2 <= hs_s1;
            vs_s2 <= vs_s1;
            if (!ok_s1)
                rgb_s2 <= '0;
            else if (sd_s1)
                rgb_s2 <= {atten(rd_dat[CW-1 -: COLOR_DEPTH], scanlines),
                           atten(rd_dat[2*COLOR_DEPTH-1 -: COLOR_DEPTH], scanlines),
                           atten(rd_dat[COLOR_DEPTH-1:0], scanlines)};
            else
                rgb_s2 <= rd_dat;
        end
    end

    assign vid_rgb = rgb_s2;
    assign vid_hs  = hs_s2;
    assign vid_vs  = vs_s2;
`else
    assign vid_rgb = ok_s1 ? rd_dat : '0;
    assign vid_hs  = hs_s1;
    assign vid_vs  = vs_s1;
`endif

    // Bypass copies run every clk_sys; the buffer keeps capturing underneath
    // so switching modes needs no resync.
    logic          byp_sel, byp_hs, byp_vs;
    logic [CW-1:0] byp_rgb;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            byp_sel <= 1'b0;
            byp_rgb <= '0;
            byp_hs  <= 1'b1;
            byp_vs  <= 1'b1;
        end else begin
            byp_sel <= bypass;
            byp_rgb <= {R_in, G_in, B_in};
            byp_hs  <= HSync_in;
            byp_vs  <= VSync_in;
        end
    end

    assign {R_out, G_out, B_out} = byp_sel ? byp_rgb : vid_rgb;
    assign HSync                 = byp_sel ? byp_hs  : vid_hs;
    assign VSync                 = byp_sel ? byp_vs  : vid_vs;

endmodule
